// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble)
// method, one bit per clock. Accepts an optionally signed binary value over a
// valid/ready handshake, returns its magnitude as BCD digits with a sign flag,
// a saturating overflow flag and a leading-zero mask.
module bin_to_bcd_seq #(
  parameter int BIN_WIDTH = 16,
  parameter int DIGITS    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_WIDTH-1:0]  bin_in,
  input  logic                  signed_en,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIGITS*4-1:0]   bcd_out,
  output logic                  negative,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(BIN_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [BIN_WIDTH-1:0] mag_q;
  logic [BCD_W-1:0]     bcd_q;
  logic                 neg_q;
  logic                 ovf_q;
  logic [CNT_W-1:0]     cnt_q;

  logic [BCD_W-1:0]     bcd_adj;
  logic [BIN_WIDTH-1:0] mag_in;
  logic                 neg_in;
  logic                 last_step;
  logic                 zero_above;

  // The counter reaches BIN_WIDTH after the final shift; that SHIFT cycle is
  // spent handing over to DONE, giving a BIN_WIDTH+1 cycle latency.
  assign last_step = (cnt_q == CNT_W'(BIN_WIDTH));

  // Magnitude of the incoming value; the most-negative input negates to
  // itself, which read as unsigned is exactly 2^(BIN_WIDTH-1).
  assign neg_in = signed_en & bin_in[BIN_WIDTH-1];
  assign mag_in = neg_in ? (~bin_in + BIN_WIDTH'(1)) : bin_in;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = SHIFT;
      SHIFT:   if (last_step) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Add-3 correction on every digit of 5 or more, ahead of the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
  end

  // Datapath: capture in IDLE, one double-dabble step per SHIFT cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag_q <= '0;
      bcd_q <= '0;
      neg_q <= 1'b0;
      ovf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mag_q <= mag_in;
            neg_q <= neg_in;
            bcd_q <= '0;
            ovf_q <= 1'b0;
            cnt_q <= '0;
          end
        end
        SHIFT: begin
          if (!last_step) begin
            // A set top bit here would be shifted out: the value no longer fits.
            if (bcd_adj[BCD_W-1]) ovf_q <= 1'b1;
            bcd_q <= {bcd_adj[BCD_W-2:0], mag_q[BIN_WIDTH-1]};
            mag_q <= {mag_q[BIN_WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Handshake and result outputs; results are driven only while in DONE.
  always_comb begin
    in_ready   = (state_q == IDLE);
    out_valid  = (state_q == DONE);
    bcd_out    = '0;
    negative   = 1'b0;
    overflow   = 1'b0;
    blank_mask = '0;
    zero_above = 1'b1;
    if (state_q == DONE) begin
      negative = neg_q;
      overflow = ovf_q;
      if (ovf_q) begin
        for (int k = 0; k < DIGITS; k++) bcd_out[4*k +: 4] = 4'd9;
      end else begin
        bcd_out = bcd_q;
        // Digit 0 is never blanked, so a zero result still shows one digit.
        for (int k = DIGITS - 1; k >= 1; k--) begin
          zero_above    = zero_above & (bcd_q[4*k +: 4] == 4'd0);
          blank_mask[k] = zero_above;
        end
      end
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 5-digit and a 4-digit instance share the same
// stimulus; results are compared with an arithmetic decimal model.
module tb_bin_to_bcd_seq;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [W-1:0] bin_in;
  logic        signed_en;
  logic        out_ready;

  logic        in_ready5, out_valid5, negative5, overflow5;
  logic [19:0] bcd5;
  logic [4:0]  blank5;
  logic        in_ready4, out_valid4, negative4, overflow4;
  logic [15:0] bcd4;
  logic [3:0]  blank4;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_WIDTH(W), .DIGITS(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready5),
    .bin_in(bin_in), .signed_en(signed_en), .out_valid(out_valid5),
    .out_ready(out_ready), .bcd_out(bcd5), .negative(negative5),
    .overflow(overflow5), .blank_mask(blank5)
  );

  bin_to_bcd_seq #(.BIN_WIDTH(W), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .bin_in(bin_in), .signed_en(signed_en), .out_valid(out_valid4),
    .out_ready(out_ready), .bcd_out(bcd4), .negative(negative4),
    .overflow(overflow4), .blank_mask(blank4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic longint pow10(input int d);
    longint p = 1;
    for (int i = 0; i < d; i++) p = p * 10;
    return p;
  endfunction

  function automatic longint model_mag(input logic [W-1:0] b, input logic s);
    if (s && b[W-1]) return longint'(65536) - longint'(b);
    return longint'(b);
  endfunction

  function automatic logic model_ovf(input longint m, input int d);
    return m > pow10(d) - 1;
  endfunction

  function automatic logic [63:0] model_bcd(input longint m, input int d);
    logic [63:0] r = '0;
    longint v = model_ovf(m, d) ? pow10(d) - 1 : m;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] model_blank(input longint m, input int d);
    logic [63:0] r = '0;
    if (model_ovf(m, d)) return r;
    for (int k = 1; k < d; k++) r[k] = (m < pow10(k));
    return r;
  endfunction

  // One complete conversion: accept, scrambled inputs while busy, latency and
  // result checks, optional back-pressure, then the output handshake.
  task automatic convert(input logic [W-1:0] b, input logic s, input int hold);
    longint m = model_mag(b, s);
    int n = 0;
    logic exp_neg = s & b[W-1];
    check("ready_before_accept", 64'(in_ready5), 64'(1));
    bin_in = b; signed_en = s; in_valid = 1'b1;
    @(posedge clk); #1;
    check("busy_after_accept", 64'({in_ready5, in_ready4}), 64'(0));
    while (n < 60 && !out_valid5) begin
      bin_in = W'($urandom); in_valid = 1'($urandom); signed_en = 1'($urandom);
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    check("latency", 64'(n), 64'(W + 1));
    check("valid4", 64'(out_valid4), 64'(1));
    check("bcd5", 64'(bcd5), model_bcd(m, 5));
    check("neg5", 64'(negative5), 64'(exp_neg));
    check("ovf5", 64'(overflow5), 64'(model_ovf(m, 5)));
    check("blank5", 64'(blank5), model_blank(m, 5));
    check("bcd4", 64'(bcd4), model_bcd(m, 4));
    check("neg4", 64'(negative4), 64'(exp_neg));
    check("ovf4", 64'(overflow4), 64'(model_ovf(m, 4)));
    check("blank4", 64'(blank4), model_blank(m, 4));
    for (int i = 0; i < hold; i++) begin
      bin_in = W'($urandom); in_valid = 1'($urandom);
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid5), 64'(1));
      check("hold_ready", 64'(in_ready5), 64'(0));
      check("hold_bcd5", 64'(bcd5), model_bcd(m, 5));
      check("hold_bcd4", 64'(bcd4), model_bcd(m, 4));
    end
    // A pending input during the handshake edge must not be captured.
    out_ready = 1'b1; in_valid = 1'b1; bin_in = W'($urandom);
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("idle_after_handshake", 64'({in_ready5, out_valid5}), 64'(2'b10));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; bin_in = '0; signed_en = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'({in_ready5, in_ready4}), 64'(2'b11));
    check("rst_valid", 64'({out_valid5, out_valid4}), 64'(0));
    check("rst_outs5", 64'({bcd5, negative5, overflow5, blank5}), 64'(0));
    check("rst_outs4", 64'({bcd4, negative4, overflow4, blank4}), 64'(0));
    rst = 1'b0;

    convert(16'd12345, 1'b0, 0);
    convert(16'd0,     1'b0, 0);
    convert(16'd65535, 1'b0, 0);
    convert(16'hFFFF,  1'b1, 0);
    convert(16'h8000,  1'b1, 0);
    convert(16'd9999,  1'b0, 0);
    convert(16'd10000, 1'b0, 10);
    convert(16'd7,     1'b1, 0);
    for (int i = 0; i < 25; i++) convert(W'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // Reset in the middle of a conversion aborts it.
    bin_in = 16'd54321; signed_en = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", 64'({in_ready5, in_ready4}), 64'(2'b11));
    check("abort_valid", 64'({out_valid5, out_valid4}), 64'(0));
    check("abort_outs5", 64'({bcd5, negative5, overflow5, blank5}), 64'(0));
    check("abort_outs4", 64'({bcd4, negative4, overflow4, blank4}), 64'(0));
    convert(16'd42, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
BIN_TO_BCD_SEQ -- requirements
Module: bin_to_bcd_seq

Interface
REQ-001 The block SHALL have parameter BIN_WIDTH, default 16, meaning the binary input width (range 4..32).
REQ-002 The block SHALL have parameter DIGITS, default 5, meaning the number of BCD output digits (range 1..10).
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port clk: input, 1 bit, the single clock; all logic is rising-edge.
REQ-005 Port rst: input, 1 bit, synchronous active-high reset.
REQ-006 Port in_valid: input, 1 bit, bin_in and signed_en are valid.
REQ-007 Port in_ready: output, 1 bit, the block can accept a conversion.
REQ-008 Port bin_in: input, BIN_WIDTH bits, the value to convert.
REQ-009 Port signed_en: input, 1 bit, 1 = treat bin_in as two's complement.
REQ-010 Port out_valid: output, 1 bit, the result ports are valid.
REQ-011 Port out_ready: input, 1 bit, the consumer accepts the result.
REQ-012 Port bcd_out: output, DIGITS*4 bits, digit k at bits [4k+3:4k], with digit 0 the least significant.
REQ-013 Port negative: output, 1 bit, the result magnitude was taken from a negative input.
REQ-014 Port overflow: output, 1 bit, the magnitude exceeds 10^DIGITS-1.
REQ-015 Port blank_mask: output, DIGITS bits, bit k = 1 means digit k is a leading zero.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 In IDLE with in_valid=1, the block SHALL capture its inputs, load the BCD register with zeros, clear the overflow flag and go to SHIFT; with in_valid=0 it SHALL stay in IDLE.
REQ-019 On capture the magnitude SHALL be computed as follows:
- signed_en=1 and bin_in MSB=1: magnitude = two's-complement negation of bin_in, as an unsigned BIN_WIDTH-bit value, and negative is set to 1.
- Otherwise: magnitude = bin_in and negative is set to 0.
- The most-negative input SHALL yield 2^(BIN_WIDTH-1) with no error.
REQ-020 SHIFT SHALL perform one double-dabble step per cycle, for exactly BIN_WIDTH cycles, counted by a bit counter:
- First, add 3 to every BCD digit whose value is at least 5.
- Then shift {BCD register, magnitude} left by one bit.
REQ-021 If the top BCD bit is 1 immediately before any shift, the overflow flag SHALL be set and SHALL stay set for that conversion.
REQ-022 After the final shift the FSM SHALL go to DONE, so out_valid rises exactly BIN_WIDTH+1 cycles after the accepting clock edge.
REQ-023 In DONE, bcd_out SHALL be as follows:
- overflow=0: the converted digits.
- overflow=1: every digit equal to 9, i.e. saturated.
REQ-024 blank_mask bit k (k≥1) SHALL be 1 when digit k and all higher digits are zero; bit 0 SHALL always be 0, and the whole mask SHALL be 0 when overflow=1.
REQ-025 In DONE, all outputs SHALL hold stable while out_ready=0; when out_ready=1 the FSM SHALL go to IDLE on that edge.
REQ-026 No new input SHALL be accepted in the cycle of the output handshake; the next input is accepted at the earliest one cycle later, in IDLE.
REQ-027 in_valid and bin_in SHALL be ignored outside IDLE, including any changes to them mid-conversion.

Reset
REQ-028 When rst=1 at a clock edge, the block SHALL set:
- the state to IDLE;
- in_ready=1 and out_valid=0;
- bcd_out, negative, overflow, blank_mask and the bit counter all to 0.
REQ-029 A reset asserted in SHIFT or DONE SHALL abort the conversion, with no out_valid pulse for it.
REQ-030 The first input after reset release SHALL be acceptable on the first edge at which rst=0.

Verification
REQ-031 The bench SHALL cover these scenarios with the default parameters unless another value is stated:
- Input 12345 with signed_en=0 → digits 1,2,3,4,5; negative=0; overflow=0; blank_mask=00000; out_valid 17 cycles after accept.
- Input 0 → all digits 0 and blank_mask=11110; input 65535 with signed_en=0 → 6,5,5,3,5.
- Input 0xFFFF with signed_en=1 → magnitude 00001, negative=1; input 0x8000 with signed_en=1 → 3,2,7,6,8, negative=1.
- With DIGITS=4: input 9999 → 9999, overflow=0; input 10000 → overflow=1, bcd_out=9999, blank_mask=0000.
- Hold out_ready=0 for 10 cycles → outputs stable and in_ready=0 throughout; raise out_ready → in_ready=1 on the next cycle.
- Assert rst at SHIFT cycle 8 → next cycle state IDLE with all outputs 0; a new input of 42 → 00042 with no stale data.
